// File: rtl/dpram_port_arbiter_if.sv
// Client and RAM-side signal bundle for the dual-port RAM arbiter.
// The arbiter takes the slave view; the clients and the RAM take the master view.
interface dpram_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 10,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [NREQ*DW-1:0] rdata;
    logic [AW-1:0]      ram_addr1;
    logic [AW-1:0]      ram_addr2;
    logic [DW-1:0]      ram_data1;
    logic [DW-1:0]      ram_data2;
    logic               ram_we1;
    logic               ram_we2;
    logic [DW-1:0]      ram_out1;
    logic [DW-1:0]      ram_out2;

    modport slave (
        input  req, req_we, req_addr, req_wdata, ram_out1, ram_out2,
        output gnt, rvalid, rdata,
               ram_addr1, ram_addr2, ram_data1, ram_data2, ram_we1, ram_we2
    );

    modport master (
        output req, req_we, req_addr, req_wdata, ram_out1, ram_out2,
        input  gnt, rvalid, rdata,
               ram_addr1, ram_addr2, ram_data1, ram_data2, ram_we1, ram_we2
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM among NREQ clients.
// Up to two grants per cycle (port 1 = first requester from ptr, port 2 = next one),
// with the second grant withheld on a same-address hazard involving a write.
// Read data returns to the originator one cycle after its grant.
module dpram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 10,
    parameter int DW   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dpram_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    logic [AW-1:0] addr  [NREQ];
    logic [DW-1:0] wdata [NREQ];

    logic          a_vld, b_vld, conflict, a_gnt, b_gnt;
    logic [PW-1:0] a_idx, b_idx;

    logic          tag1_vld, tag2_vld;
    logic [PW-1:0] tag1_idx, tag2_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr[g]  = bus.req_addr[g*AW +: AW];
        assign wdata[g] = bus.req_wdata[g*DW +: DW];
    end

    // Arguments never exceed 2*NREQ-2, so one subtraction is enough to wrap.
    function automatic logic [PW-1:0] wrap_idx(input int v);
        int s;
        s = v;
        if (s >= NREQ) s -= NREQ;
        return PW'(s);
    endfunction

    // Scan from ptr: first requester wins port 1, the next one wins port 2
    always_comb begin
        a_vld = 1'b0;
        b_vld = 1'b0;
        a_idx = '0;
        b_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req[wrap_idx(int'(ptr) + k)]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = wrap_idx(int'(ptr) + k);
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    b_idx = wrap_idx(int'(ptr) + k);
                end
            end
        end
    end

    // Same-address pairs are only safe when both are reads; otherwise B retries.
    assign conflict = a_vld && b_vld && (addr[a_idx] == addr[b_idx]) &&
                      (bus.req_we[a_idx] || bus.req_we[b_idx]);
    assign a_gnt    = rst_n && a_vld;
    assign b_gnt    = rst_n && b_vld && !conflict;

    // Grant vector and RAM port drive; idle ports are held at zero
    always_comb begin
        bus.gnt       = '0;
        bus.ram_addr1 = '0;
        bus.ram_data1 = '0;
        bus.ram_we1   = 1'b0;
        bus.ram_addr2 = '0;
        bus.ram_data2 = '0;
        bus.ram_we2   = 1'b0;
        if (a_gnt) begin
            bus.gnt[a_idx] = 1'b1;
            bus.ram_addr1  = addr[a_idx];
            bus.ram_data1  = wdata[a_idx];
            bus.ram_we1    = bus.req_we[a_idx];
        end
        if (b_gnt) begin
            bus.gnt[b_idx] = 1'b1;
            bus.ram_addr2  = addr[b_idx];
            bus.ram_data2  = wdata[b_idx];
            bus.ram_we2    = bus.req_we[b_idx];
        end
    end

    // Round-robin pointer advance and read-return tags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            tag1_vld <= 1'b0;
            tag2_vld <= 1'b0;
            tag1_idx <= '0;
            tag2_idx <= '0;
        end else begin
            if (b_gnt) begin
                ptr <= wrap_idx(int'(b_idx) + 1);
            end else if (a_gnt) begin
                ptr <= wrap_idx(int'(a_idx) + 1);
            end
            tag1_vld <= a_gnt && !bus.req_we[a_idx];
            tag1_idx <= a_idx;
            tag2_vld <= b_gnt && !bus.req_we[b_idx];
            tag2_idx <= b_idx;
        end
    end

    // Steer each port's RAM output to its tagged requester. rst_n gates the
    // pulse so a read granted just before reset never reports back.
    always_comb begin
        bus.rvalid = '0;
        bus.rdata  = '0;
        if (rst_n && tag1_vld) begin
            bus.rvalid[tag1_idx]               = 1'b1;
            bus.rdata[int'(tag1_idx)*DW +: DW] = bus.ram_out1;
        end
        if (rst_n && tag2_vld) begin
            bus.rvalid[tag2_idx]               = 1'b1;
            bus.rdata[int'(tag2_idx)*DW +: DW] = bus.ram_out2;
        end
    end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: behavioural dual-port RAM, scenario tasks with
// inline grant/port checks, and a scoreboard of expected read returns.
module tb_dpram_port_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t keep[$];
    logic [NREQ-1:0] mon_mask;
    logic [15:0]     mon_data [NREQ];

    logic [15:0] mem [1024];

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 37 + 4096);
    endfunction

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] <= init_val(a);
    end

    // Dual-port RAM model with registered read data
    always @(posedge clk) begin
        if (bus.ram_we1) mem[bus.ram_addr1] <= bus.ram_data1;
        if (bus.ram_we2) mem[bus.ram_addr2] <= bus.ram_data2;
        bus.ram_out1 <= mem[bus.ram_addr1];
        bus.ram_out2 <= mem[bus.ram_addr2];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every cycle, rvalid must match exactly the reads due now
    always @(negedge clk) begin
        mon_mask = '0;
        for (int i = 0; i < NREQ; i++) mon_data[i] = '0;
        keep = {};
        foreach (sb[j]) begin
            if (sb[j].cyc == cyc) begin
                mon_mask[sb[j].idx] = 1'b1;
                mon_data[sb[j].idx] = sb[j].data;
            end else begin
                keep.push_back(sb[j]);
            end
        end
        sb = keep;
        checks++;
        if (bus.rvalid !== mon_mask) begin
            failures++;
            $display("FAIL rvalid cyc=%0d: got %b expected %b", cyc, bus.rvalid, mon_mask);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (mon_mask[i]) begin
                checks++;
                if (bus.rdata[i*DW +: DW] !== mon_data[i]) begin
                    failures++;
                    $display("FAIL rdata%0d cyc=%0d: got %h expected %h",
                             i, cyc, bus.rdata[i*DW +: DW], mon_data[i]);
                end
            end
        end
    end

    task automatic clear_reqs();
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req[i]              = 1'b1;
        bus.req_we[i]           = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic push_read(input int i, input logic [15:0] d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.idx  = i;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        next_cycle();
        clear_reqs();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0000) begin
            failures++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt);
        end
        checks++;
        if ({bus.ram_we1, bus.ram_we2} !== 2'b00) begin
            failures++; $display("FAIL reset_we: got %b expected 00", {bus.ram_we1, bus.ram_we2});
        end
        checks++;
        if (bus.ram_addr1 !== '0 || bus.ram_addr2 !== '0) begin
            failures++; $display("FAIL reset_addr: got %h/%h expected 0/0", bus.ram_addr1, bus.ram_addr2);
        end
        checks++;
        if (bus.rvalid !== 4'b0000) begin
            failures++; $display("FAIL reset_rvalid: got %b expected 0000", bus.rvalid);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0011) begin
            failures++; $display("FAIL first_gnt: got %b expected 0011", bus.gnt);
        end
        push_read(0, init_val(0));
        push_read(1, init_val(0));
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b1100) begin
            failures++; $display("FAIL ptr_after_reset: got %b expected 1100", bus.gnt);
        end
        push_read(2, init_val(0));
        push_read(3, init_val(0));
        idle_cycle();
    endtask

    task automatic test_dual_write_read();
        next_cycle();
        clear_reqs();
        set_req(0, 1'b1, 10'd1, 16'ha45a);
        set_req(1, 1'b1, 10'd2, 16'h1342);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0011) begin
            failures++; $display("FAIL dual_write_gnt: got %b expected 0011", bus.gnt);
        end
        checks++;
        if ({bus.ram_we1, bus.ram_addr1, bus.ram_data1, bus.ram_we2, bus.ram_addr2, bus.ram_data2}
            !== {1'b1, 10'd1, 16'ha45a, 1'b1, 10'd2, 16'h1342}) begin
            failures++;
            $display("FAIL dual_write_ports: got p1 %b/%h/%h p2 %b/%h/%h expected p1 1/001/a45a p2 1/002/1342",
                     bus.ram_we1, bus.ram_addr1, bus.ram_data1, bus.ram_we2, bus.ram_addr2, bus.ram_data2);
        end
        next_cycle();
        clear_reqs();
        set_req(0, 1'b0, 10'd1, '0);
        set_req(1, 1'b0, 10'd2, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0011) begin
            failures++; $display("FAIL dual_read_gnt: got %b expected 0011", bus.gnt);
        end
        push_read(0, 16'ha45a);
        push_read(1, 16'h1342);
        idle_cycle();
    endtask

    task automatic test_conflict();
        next_cycle();
        clear_reqs();
        set_req(0, 1'b1, 10'd3, 16'hadff);
        set_req(1, 1'b0, 10'd3, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++; $display("FAIL conflict_gnt: got %b expected 0001", bus.gnt);
        end
        checks++;
        if ({bus.ram_we2, bus.ram_addr2} !== {1'b0, 10'd0}) begin
            failures++; $display("FAIL conflict_port2_idle: got %b/%h expected 0/000", bus.ram_we2, bus.ram_addr2);
        end
        next_cycle();
        clear_reqs();
        set_req(1, 1'b0, 10'd3, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++; $display("FAIL conflict_retry_gnt: got %b expected 0010", bus.gnt);
        end
        push_read(1, 16'hadff);
        idle_cycle();
    endtask

    task automatic test_same_addr_reads();
        next_cycle();
        clear_reqs();
        set_req(2, 1'b1, 10'd5, 16'h1234);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++; $display("FAIL prefill_gnt: got %b expected 0100", bus.gnt);
        end
        next_cycle();
        clear_reqs();
        set_req(2, 1'b0, 10'd5, '0);
        set_req(3, 1'b0, 10'd5, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b1100) begin
            failures++; $display("FAIL same_addr_gnt: got %b expected 1100", bus.gnt);
        end
        checks++;
        if ({bus.ram_addr1, bus.ram_addr2} !== {10'd5, 10'd5}) begin
            failures++; $display("FAIL same_addr_ports: got %h/%h expected 005/005", bus.ram_addr1, bus.ram_addr2);
        end
        push_read(2, 16'h1234);
        push_read(3, 16'h1234);
        idle_cycle();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int waits [NREQ];
        int maxw;
        next_cycle();
        clear_reqs();
        set_req(3, 1'b0, 10'd7, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++; $display("FAIL rr_align_gnt: got %b expected 1000", bus.gnt);
        end
        push_read(3, init_val(7));
        maxw = 0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            clear_reqs();
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(16 + i), '0);
            @(negedge clk);
            exp_gnt = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            checks++;
            if (bus.gnt !== exp_gnt) begin
                failures++; $display("FAIL rr_gnt c=%0d: got %b expected %b", c, bus.gnt, exp_gnt);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i]) begin
                    if (!bus.req_we[i]) push_read(i, init_val(16 + i));
                    waits[i] = 0;
                end else begin
                    waits[i]++;
                    if (waits[i] > maxw) maxw = waits[i];
                end
            end
        end
        checks++;
        if (maxw > 2) begin
            failures++; $display("FAIL rr_max_wait: got %0d expected <= 2", maxw);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        clear_reqs();
        set_req(0, 1'b0, 10'd20, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++; $display("FAIL mid_read_gnt: got %b expected 0001", bus.gnt);
        end
        next_cycle();
        clear_reqs();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 4'b0000) begin
            failures++; $display("FAIL mid_read_rvalid: got %b expected 0000", bus.rvalid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) idle_cycle();
        next_cycle();
        clear_reqs();
        set_req(0, 1'b0, 10'd21, '0);
        set_req(3, 1'b0, 10'd22, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b1001) begin
            failures++; $display("FAIL post_reset_gnt: got %b expected 1001", bus.gnt);
        end
        checks++;
        if ({bus.ram_addr1, bus.ram_addr2} !== {10'd21, 10'd22}) begin
            failures++; $display("FAIL post_reset_ptr: got %h/%h expected 015/016", bus.ram_addr1, bus.ram_addr2);
        end
        push_read(0, init_val(21));
        push_read(3, init_val(22));
        idle_cycle();
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_dual_write_read();
        test_conflict();
        test_same_addr_reads();
        test_round_robin();
        test_reset_mid_read();
        repeat (2) idle_cycle();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
